// File: rtl/fetch_pkg.sv
`default_nettype none
// =====================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, reset PC, NOP encoding and queue entry type.
// Revision : 1.0
// =====================================================================
package fetch_pkg;

  localparam int c_XLEN = 64;
  localparam int c_ILEN = 32;
  localparam logic [c_XLEN-1:0] c_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [c_ILEN-1:0] c_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [c_XLEN-1:0] word_align(input logic [c_XLEN-1:0] addr);
    return addr & {{(c_XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// =====================================================================
// Module   : fetch_if
// Brief    : Instruction memory request/grant/response bus.
// Revision : 1.0
// =====================================================================
interface fetch_if;
  import fetch_pkg::*;

  logic              fetch_o_imem_req;
  logic [c_XLEN-1:0] fetch_o_imem_addr;
  logic              imem_i_gnt;
  logic              imem_i_rvalid;
  logic [c_ILEN-1:0] imem_i_rdata;

  modport master (
    output fetch_o_imem_req, fetch_o_imem_addr,
    input  imem_i_gnt, imem_i_rvalid, imem_i_rdata
  );

  modport slave (
    input  fetch_o_imem_req, fetch_o_imem_addr,
    output imem_i_gnt, imem_i_rvalid, imem_i_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// =====================================================================
// Module   : fetch_queue
// Brief    : Synchronous {pc, instr} FIFO with push/pop/flush; flush wins.
// Revision : 1.0
// =====================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw:0]   r_count;
  logic            w_do_pop;
  logic            w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A simultaneous pop frees the slot, so push at full still lands.
  assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// =====================================================================
// Module   : fetch
// Brief    : Credit-limited instruction fetch with redirect discard.
//            FETCH_PERF_CNT_EN adds the fetch_o_bubble_cnt counter.
// Revision : 1.0
// =====================================================================
module fetch
  import fetch_pkg::*;
#(
  parameter logic [c_XLEN-1:0] RESET_PC = c_RESET_PC,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_if.master           imem,
  input  logic              execute_i_redirect,
  input  logic [c_XLEN-1:0] execute_i_redirect_pc,
  input  logic              regD_i_ready,
  output logic              fetch_o_valid,
  output logic [c_ILEN-1:0] fetch_o_instr,
  output logic [c_XLEN-1:0] fetch_o_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]       fetch_o_bubble_cnt
`endif
);

  localparam int            c_cw    = $clog2(QDEPTH) + 1;
  localparam logic [c_cw:0] c_limit = (c_cw+1)'(QDEPTH);

  logic [c_XLEN-1:0] r_fetch_pc;
  logic [c_XLEN-1:0] r_resp_pc;
  logic [c_cw-1:0]   r_outstanding;
  logic [c_cw-1:0]   r_discard;
  logic [c_cw-1:0]   w_out_nxt;
  logic [c_cw-1:0]   w_count;
  logic [c_cw:0]     w_load;
  logic              w_req;
  logic              w_gnt;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_pop  = fetch_o_valid & regD_i_ready;
  // The slot freed by this cycle's pop is credited at once so a 2-deep queue streams.
  assign w_load = {1'b0, r_outstanding} + {1'b0, w_count} - {{c_cw{1'b0}}, w_pop};
  assign w_req  = rst & ~execute_i_redirect & (w_load < c_limit);
  assign w_gnt  = w_req & imem.imem_i_gnt;
  assign w_rsp  = imem.imem_i_rvalid;
  assign w_drop = w_rsp & (r_discard != '0);
  assign w_push = w_rsp & ~w_drop;

  assign imem.fetch_o_imem_req  = w_req;
  assign imem.fetch_o_imem_addr = rst ? r_fetch_pc : '0;

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_gnt, w_rsp})
      2'b10:   w_out_nxt = r_outstanding + c_cw'(1);
      2'b01:   w_out_nxt = r_outstanding - c_cw'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_nxt;
      if (execute_i_redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= word_align(execute_i_redirect_pc);
        r_resp_pc  <= word_align(execute_i_redirect_pc);
        r_discard  <= w_out_nxt;
      end else begin
        if (w_gnt)  r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_push) r_resp_pc  <= r_resp_pc + 64'd4;
        if (w_drop) r_discard  <= r_discard - c_cw'(1);
      end
    end
  end

  assign w_push_data = '{pc: r_resp_pc, instr: imem.imem_i_rdata};

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (execute_i_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fetch_o_valid = (w_count != '0);
  assign fetch_o_instr = w_head.instr;
  assign fetch_o_pc    = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (regD_i_ready && !fetch_o_valid && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 64'd1;
    end
  end

  assign fetch_o_bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// =====================================================================
// Module   : tb_fetch
// Brief    : Scoreboard bench for fetch with an in-order imem model.
// Revision : 1.0
// =====================================================================
module tb_fetch;
  import fetch_pkg::*;

  localparam int          QDEPTH   = 2;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        execute_i_redirect;
  logic [63:0] execute_i_redirect_pc;
  logic        regD_i_ready;
  logic        fetch_o_valid;
  logic [31:0] fetch_o_instr;
  logic [63:0] fetch_o_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_o_bubble_cnt;
  logic [63:0] m_bubble;
`endif

  fetch_if imem_if ();

  fetch #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem                  (imem_if),
    .execute_i_redirect    (execute_i_redirect),
    .execute_i_redirect_pc (execute_i_redirect_pc),
    .regD_i_ready          (regD_i_ready),
    .fetch_o_valid         (fetch_o_valid),
    .fetch_o_instr         (fetch_o_instr),
    .fetch_o_pc            (fetch_o_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_o_bubble_cnt    (fetch_o_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] addr;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [63:0]  dut_addr_log[$];
  int           n_checks;
  int           n_fail;
  int           cyc;
  int           m_out;
  int           m_qcnt;
  int           m_disc;
  int           m_lat;
  int           last_due;
  int           n_pops;
  int           n_dut_gnt;
  logic [63:0]  m_pc;
  logic [63:0]  last_pop_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ c_NOP;
  endfunction

  task automatic model_clear();
    pend.delete();
    exp_q.delete();
    m_pc     = RESET_PC;
    m_out    = 0;
    m_qcnt   = 0;
    m_disc   = 0;
    last_due = -1;
`ifdef FETCH_PERF_CNT_EN
    m_bubble = '0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst                   = 1'b0;
    imem_if.imem_i_gnt    = 1'b0;
    imem_if.imem_i_rvalid = 1'b0;
    imem_if.imem_i_rdata  = '0;
    regD_i_ready          = 1'b0;
    execute_i_redirect    = 1'b0;
    execute_i_redirect_pc = '0;
    #1;
    check_eq("rst_req", imem_if.fetch_o_imem_req, 1'b0);
    check_eq("rst_valid", fetch_o_valid, 1'b0);
    check_eq("rst_instr", fetch_o_instr, 32'h0);
    check_eq("rst_pc", fetch_o_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_bubble", fetch_o_bubble_cnt, 64'h0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_req", imem_if.fetch_o_imem_req, 1'b1);
    check_eq("rel_addr", imem_if.fetch_o_imem_addr, RESET_PC);
  endtask

  // One clock: drive at negedge, compare against the model, then advance it.
  task automatic cycle(input logic gnt, input logic rdy, input logic redir, input logic [63:0] rpc);
    logic rsp, mv, mpop, mreq;
    @(negedge clk);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_if.imem_i_rvalid = rsp;
    imem_if.imem_i_rdata  = rsp ? instr_of(pend[0].addr) : 32'h0;
    imem_if.imem_i_gnt    = gnt;
    regD_i_ready          = rdy;
    execute_i_redirect    = redir;
    execute_i_redirect_pc = rpc;
    #1;
    mv   = (m_qcnt != 0);
    mpop = mv && rdy;
    mreq = !redir && ((m_out + m_qcnt - (mpop ? 1 : 0)) < QDEPTH);
    check_eq("valid", fetch_o_valid, mv);
    check_eq("req", imem_if.fetch_o_imem_req, mreq);
    if (mv) begin
      check_eq("out_pc", fetch_o_pc, exp_q[0].pc);
      check_eq("out_instr", fetch_o_instr, exp_q[0].instr);
    end
`ifdef FETCH_PERF_CNT_EN
    check_eq("bubble", fetch_o_bubble_cnt, m_bubble);
    if (rdy && !mv && m_bubble != '1) m_bubble = m_bubble + 64'd1;
`endif
    if (imem_if.fetch_o_imem_req && gnt) begin
      n_dut_gnt++;
      dut_addr_log.push_back(imem_if.fetch_o_imem_addr);
    end
    if (mreq && gnt) begin
      check_eq("addr", imem_if.fetch_o_imem_addr, m_pc);
      last_due = (cyc + m_lat > last_due + 1) ? cyc + m_lat : last_due + 1;
      pend.push_back('{due: last_due, addr: m_pc});
      exp_q.push_back('{pc: m_pc, instr: instr_of(m_pc)});
      m_pc = m_pc + 64'd4;
      m_out++;
    end
    if (mpop) begin
      last_pop_pc = fetch_o_pc;
      n_pops++;
      void'(exp_q.pop_front());
      m_qcnt--;
    end
    if (rsp) begin
      void'(pend.pop_front());
      m_out--;
      if (m_disc > 0) m_disc--;
      else            m_qcnt++;
    end
    if (redir) begin
      exp_q.delete();
      m_qcnt = 0;
      m_pc   = rpc & ~64'h3;
      m_disc = m_out;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || pend.size() != 0); i++) cycle(1'b0, 1'b1, 1'b0, '0);
    check_eq("drained", exp_q.size(), 0);
  endtask

  task automatic wait_out2();
    for (int i = 0; i < 20 && m_out != 2; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("two_outstanding", m_out, 2);
  endtask

  task automatic first_pop_pc(input string tag, input logic [63:0] want);
    int p0;
    p0 = n_pops;
    for (int i = 0; i < 30 && n_pops == p0; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq(tag, last_pop_pc, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    n_pops      = 0;
    n_dut_gnt   = 0;
    last_pop_pc = '0;
    m_lat       = 1;
    rst         = 1'b0;
    model_clear();
    apply_reset();

    // Streaming: addresses in consecutive cycles, one-cycle response latency.
    dut_addr_log.delete();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("stream_a0", dut_addr_log[0], 64'h8000_0000);
    check_eq("stream_a1", dut_addr_log[1], 64'h8000_0004);
    check_eq("stream_a2", dut_addr_log[2], 64'h8000_0008);
    check_eq("stream_gnts", dut_addr_log.size(), 12);

    // Decode stall: credit bound limits grants.
    g0 = n_dut_gnt;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("stall_grants_le_q", (n_dut_gnt - g0) <= QDEPTH, 1'b1);
    check_eq("stall_req_low", imem_if.fetch_o_imem_req, 1'b0);
    drain();

    // Redirect with two outstanding, unaligned target.
    m_lat = 3;
    wait_out2();
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0102);
    first_pop_pc("redir_first_pc", 64'h8000_0100);
    drain();

    // Redirect coincident with response and pop.
    m_lat = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    check_eq("coinc_valid_before", fetch_o_valid, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_1000);
    @(posedge clk);
    #1;
    check_eq("coinc_empty_after", fetch_o_valid, 1'b0);
    drain();

    // Back-to-back redirects with two outstanding.
    m_lat = 3;
    wait_out2();
    cycle(1'b1, 1'b1, 1'b1, 64'h9000_0000);
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0200);
    first_pop_pc("b2b_first_pc", 64'h8000_0200);
    drain();

    // 64-bit PC wrap.
    m_lat = 1;
    cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      m_lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, {32'h0, $urandom()});
    end
    drain();

    // Reset with a full queue.
    m_lat = 1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check_eq("full_valid_before_rst", fetch_o_valid, 1'b1);
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);
`ifdef FETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    check_eq("bubble5", fetch_o_bubble_cnt, 64'd5);
`endif
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2: instruction queue depth; power of two, >=2.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 fetch_o_imem_req  out  1  instruction memory request valid.
REQ-006 fetch_o_imem_addr  out  64  request address, word aligned.
REQ-007 imem_i_gnt  in  1  request accepted this cycle; ignored when req low.
REQ-008 imem_i_rvalid  in  1  response valid; in order; one per granted request; latency >=1 cycle.
REQ-009 imem_i_rdata  in  32  response instruction word.
REQ-010 execute_i_redirect  in  1  branch/jump redirect, single-cycle pulse.
REQ-011 execute_i_redirect_pc  in  64  redirect target.
REQ-012 regD_i_ready  in  1  decode pipeline register accepts an instruction.
REQ-013 fetch_o_valid  out  1  fetch_o_instr and fetch_o_pc valid.
REQ-014 fetch_o_instr  out  32  instruction to decode.
REQ-015 fetch_o_pc  out  64  PC of fetch_o_instr.

Function
REQ-016 Credit rule: outstanding (granted, not returned) + queue occupancy SHALL never exceed QDEPTH; req asserted only when below QDEPTH and no redirect this cycle.
REQ-017 On req&gnt: fetch PC += 4 (64-bit wrap), outstanding += 1.
REQ-018 Response PC register tracks the PC of the next expected response, += 4 per accepted (non-discarded) response.
REQ-019 Accepted response in cycle N SHALL be pushed as {resp_pc, rdata} and be visible on fetch_o_valid in cycle N+1; no combinational bypass.
REQ-020 fetch_o_valid = queue non-empty; head popped on fetch_o_valid & regD_i_ready; outputs held stable while valid & !ready.
REQ-021 Push and pop in the same cycle SHALL both take effect, including at full (occupancy unchanged).
REQ-022 Redirect in cycle N: queue flushed; fetch PC and response PC <= {redirect_pc[63:2], 2'b00}; discard counter <= outstanding after this cycle's response and grant; req low in N; fetch_o_valid low in N+1; first request at target in N+1.
REQ-023 While discard counter > 0, each rvalid SHALL be dropped and decrement it; no push.
REQ-024 Redirect while discard counter > 0 SHALL add the still-outstanding count (no response lost or double-counted).
REQ-025 Pop in a redirect cycle is allowed; the popped entry is the last delivered pre-redirect instruction.

Reset
REQ-026 On rst low, asynchronously: fetch PC = response PC = RESET_PC, queue empty, outstanding = discard = 0, fetch_o_imem_req = 0, fetch_o_valid = 0, fetch_o_instr = 0, fetch_o_pc = 0.
REQ-027 First request SHALL be issued in the first rising edge cycle after rst deasserts; any response arriving for a pre-reset request is a system error, not handled.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: extra output fetch_o_bubble_cnt (64 bits), reset 0, increments each cycle regD_i_ready & !fetch_o_valid, saturates at all-ones.
REQ-029 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package holds: RESET_PC default, instruction width 32, XLEN 64, NOP encoding 32'h0000_0013.
REQ-031 Sub-module fetch_queue: synchronous FIFO {pc, instr}, QDEPTH entries, push/pop/flush, count output; flush wins over push in the same cycle.

Verification
REQ-032 Reset release, gnt=1, rdata latency 1, ready=1 -> addresses 0x8000_0000, _0004, _0008 in consecutive cycles; fetch_o_pc follows one cycle after each response.
REQ-033 ready=0 for 10 cycles, QDEPTH=2 -> at most 2 grants, req low afterwards, fetch_o_instr stable; ready=1 -> drains in order, no loss.
REQ-034 Two requests outstanding, redirect to 0x8000_0102 -> next addr 0x8000_0100; both stale responses dropped; first valid instr has pc 0x8000_0100.
REQ-035 Redirect coincident with rvalid and pop -> response dropped, popped entry is pre-redirect, queue empty next cycle.
REQ-036 Back-to-back redirects (cycles N, N+1) with 2 outstanding -> only target of N+1 delivered, discard count exact.
REQ-037 rst asserted mid-stream with queue full -> all outputs 0 immediately; FETCH_PERF_CNT_EN build: counter returns to 0 and counts 5 after 5 ready-with-empty cycles.
